// File: rtl/bit_stream_serializer.sv
// Parallel-word to gap-free serial bit stream: valid/ready input, DEPTH-word FIFO, shifter FSM.
// Build option: define SER_LSB_FIRST_EN to emit each word LSB first (default MSB first).
module bit_stream_serializer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     out_bit,
    output logic                     out_valid,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DATA_W);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DATA_W - 1);
    localparam logic [AW:0]   LVL_FULL  = (AW + 1)'(DEPTH);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [DATA_W-1:0]   sh_q, sh_d;
    logic [AW-1:0]       wptr_q, rptr_q;
    logic [AW:0]         level_q, level_d;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                push, pop, fifo_ne, last;
    logic [DATA_W-1:0]   shifted;
    logic                head_bit;

    // in_ready comes from the registered level only, so a pop never frees a slot in the same cycle
    assign in_ready = (level_q != LVL_FULL);
    assign push     = in_valid && in_ready && !rst;
    assign fifo_ne  = (level_q != '0);
    assign last     = (cnt_q == CNT_LAST);
    assign pop      = fifo_ne && ((state_q == IDLE) || last);

`ifdef SER_LSB_FIRST_EN
    assign shifted  = {1'b0, sh_q[DATA_W-1:1]};
    assign head_bit = sh_q[0];
`else
    assign shifted  = {sh_q[DATA_W-2:0], 1'b0};
    assign head_bit = sh_q[DATA_W-1];
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    sh_d    = mem[rptr_q];
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (!last) begin
                    sh_d  = shifted;
                    cnt_d = cnt_q + CW'(1);
                end else if (pop) begin
                    // back-to-back reload keeps the stream free of idle cycles
                    sh_d  = mem[rptr_q];
                    cnt_d = '0;
                end else begin
                    sh_d    = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + (AW + 1)'(1);
            2'b01:   level_d = level_q - (AW + 1)'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            level_q <= level_d;
            if (push) wptr_q <= wptr_q + AW'(1);
            if (pop)  rptr_q <= rptr_q + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr_q] <= in_data;
    end

    assign out_valid = (state_q == SHIFT);
    assign busy      = out_valid;
    assign out_bit   = head_bit & out_valid;
    assign level     = level_q;

endmodule

// File: tb/tb_bit_stream_serializer.sv
// Directed bench for bit_stream_serializer: captures the serial stream and checks it word by word.
module tb_bit_stream_serializer;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [DATA_W-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             out_bit;
    logic             out_valid;
    logic [2:0]       level;
    logic             busy;

    bit_stream_serializer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_bit  (out_bit),
        .out_valid(out_valid),
        .level    (level),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit mon_en   = 1'b0;
    bit det_clr  = 1'b0;

    bit bits[$];
    int stamps[$];
    logic [7:0] wq[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // serial position i of a word maps to this data bit
    function automatic int bitpos(input int i);
`ifdef SER_LSB_FIRST_EN
        return i;
`else
        return DATA_W - 1 - i;
`endif
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mon_en) begin
            if (out_valid) begin
                bits.push_back(out_bit);
                stamps.push_back(cyc);
            end else begin
                check("idle_bit_zero", 32'(out_bit), 32'd0);
            end
            check("busy_eq_valid", 32'(busy), 32'(out_valid));
        end
    end

    // reference sliding-window detector (pattern 1011), held in reset while out_valid is low
    logic [3:0] win;
    int         nb;
    int         hits;
    int         hit_idx;
    always @(posedge clk) begin
        if (det_clr) begin
            win <= '0; nb <= 0; hits <= 0; hit_idx <= -1;
        end else if (!out_valid) begin
            win <= '0; nb <= 0;
        end else begin
            win <= {win[2:0], out_bit};
            nb  <= nb + 1;
            if ({win[2:0], out_bit} == 4'b1011 && nb >= 3) begin
                hits <= hits + 1;
                if (hit_idx < 0) hit_idx <= nb;
            end
        end
    end

    task automatic push1(input logic [7:0] w);
        in_valid = 1'b1;
        in_data  = w;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic clear_cap;
        bits.delete();
        stamps.delete();
    endtask

    task automatic expect_stream(input string tag, input int budget);
        int n;
        int gaps;
        logic [7:0] got;
        n = 8 * wq.size();
        for (int t = 0; t < budget && bits.size() < n; t++) tick();
        check({tag, "_count"}, 32'(bits.size()), 32'(n));
        repeat (12) tick();
        check({tag, "_no_extra"}, 32'(bits.size()), 32'(n));
        if (bits.size() >= n) begin
            for (int w = 0; w < wq.size(); w++) begin
                got = '0;
                for (int i = 0; i < 8; i++) got[bitpos(i)] = bits[8 * w + i];
                check($sformatf("%s_word%0d", tag, w), 32'(got), 32'(wq[w]));
            end
            gaps = 0;
            for (int i = 1; i < n; i++) if (stamps[i] != stamps[i - 1] + 1) gaps++;
            check({tag, "_gaps"}, 32'(gaps), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int acc;
        logic [2:0] r, e;

        // reset with a word offered: nothing may be stored
        rst = 1'b1; in_valid = 1'b1; in_data = 8'h5A; det_clr = 1'b1;
        tick(); tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_bit",   32'(out_bit),   32'd0);
        check("rst_level",     32'(level),     32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_busy",      32'(busy),      32'd0);
        rst = 1'b0; in_valid = 1'b0; det_clr = 1'b0;
        tick();
        check("rst_nostore_level", 32'(level), 32'd0);
        check("rst_nostore_valid", 32'(out_valid), 32'd0);
        mon_en = 1'b1;

        // single word, latency from push edge
        clear_cap();
        push1(8'hB4);
        k = cyc;
        check("single_level1", 32'(level), 32'd1);
        check("single_not_yet", 32'(out_valid), 32'd0);
        wq.delete(); wq.push_back(8'hB4);
        expect_stream("single", 40);
        if (stamps.size() > 0) check("single_latency", 32'(stamps[0]), 32'(k + 1));

        // back-to-back words
        clear_cap();
        push1(8'hFF); push1(8'h00); push1(8'hA5);
        wq.delete(); wq.push_back(8'hFF); wq.push_back(8'h00); wq.push_back(8'hA5);
        expect_stream("b2b", 60);

        // full FIFO and held fifth word
        clear_cap();
        push1(8'h81);
        k = cyc;
        push1(8'h12); push1(8'h34); push1(8'h56); push1(8'h78);
        check("full_level", 32'(level), 32'd4);
        check("full_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1; in_data = 8'h9A; acc = -1;
        for (int t = 0; t < 40; t++) begin
            if (in_ready) begin
                acc = cyc + 1;
                tick();
                break;
            end
            tick();
        end
        in_valid = 1'b0;
        check("full_fifth_accept_cycle", 32'(acc), 32'(k + 10));
        wq.delete();
        wq.push_back(8'h81); wq.push_back(8'h12); wq.push_back(8'h34);
        wq.push_back(8'h56); wq.push_back(8'h78); wq.push_back(8'h9A);
        expect_stream("full", 100);

        // reset after 3 bits with two words queued
        clear_cap();
        push1(8'hB4); push1(8'hC3); push1(8'h5A);
        tick();
        check("midrst_level_before", 32'(level), 32'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_level", 32'(level), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        repeat (20) tick();
        check("midrst_bitcount", 32'(bits.size()), 32'd3);
        if (bits.size() >= 3) begin
            e = '0; r = '0;
            for (int i = 0; i < 3; i++) begin
                r[2 - i] = bits[i];
                e[2 - i] = 8'hB4 >> bitpos(i);
            end
            check("midrst_bits", 32'(r), 32'(e));
        end

        // end to end: pattern 1011 ends at stream bit 13
        det_clr = 1'b1; tick(); det_clr = 1'b0;
        clear_cap();
`ifdef SER_LSB_FIRST_EN
        push1(8'h00); push1(8'h34);
        wq.delete(); wq.push_back(8'h00); wq.push_back(8'h34);
`else
        push1(8'h00); push1(8'h2C);
        wq.delete(); wq.push_back(8'h00); wq.push_back(8'h2C);
`endif
        expect_stream("e2e", 50);
        check("e2e_hit_index", 32'(hit_idx), 32'd13);
        check("e2e_hit_count", 32'(hits), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bit_stream_serializer.md
# bit_stream_serializer

Upstream feeder for the sliding-window sequence detector. Accepts parallel words on a valid/ready interface, buffers them in a small FIFO, and emits them as a gap-free serial bit stream, one bit per clock, on the detector's `in` input. `out_valid` marks cycles where `out_bit` carries payload. The detector's `rst_n` is held deasserted (detector active) only while `out_valid` is high, so idle cycles are never sampled as data.

## Interface
- `DATA_W`, default 8: word width in bits; must be at least 2.
- `DEPTH`, default 4: FIFO depth in words; must be a power of 2 and at least 2.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: reset; synchronous, active-high. Sampled on the rising edge of `clk`.
- `in_data`  in  DATA_W: word to serialize.
- `in_valid`  in  1: `in_data` is valid this cycle.
- `in_ready`  out  1: FIFO can accept a word.
- `out_bit`  out  1: current serial bit; forced to 0 when `out_valid` is 0.
- `out_valid`  out  1: `out_bit` is payload.
- `level`  out  clog2(DEPTH)+1: number of words held in the FIFO. Excludes the word in the shifter.
- `busy`  out  1: shifter is in the SHIFT state.

## Operation
- **Push:** occurs when `in_valid && in_ready`.
  - `in_ready = (level != DEPTH)`, a combinational function of registered `level`.
  - A word offered while full is not accepted. The producer must hold it.
- **FIFO:** circular buffer with `DEPTH` entries.
  - Read and write pointers are each clog2(DEPTH) bits and wrap modulo DEPTH.
  - `level` is a separate counter.
  - Simultaneous push and pop: `level` is unchanged and both pointers advance.
- **Shifter FSM:** two states, IDLE and SHIFT; bit counter `cnt` counts 0..DATA_W-1.
  - IDLE, FIFO non-empty: pop the head into the shift register, `cnt`=0, go to SHIFT.
  - IDLE, FIFO empty: stay in IDLE.
  - SHIFT, `cnt` < DATA_W-1: shift by one, `cnt`+1.
  - SHIFT, `cnt` == DATA_W-1, FIFO non-empty: pop the next word, `cnt`=0, stay in SHIFT. This back-to-back reload leaves no bubble.
  - SHIFT, `cnt` == DATA_W-1, FIFO empty: go to IDLE.
- **Outputs:**
  - `out_valid` = (state == SHIFT); `busy` equals `out_valid`.
  - `out_bit` = current MSB of the shift register. Shifts are left with zero fill.
- **Pop while FIFO full:** `in_ready` does not rise in the same cycle. It rises in the next cycle, because it is derived from the registered `level`.
- **Reset** (`rst` high at an edge) takes priority over push and pop. It sets:
  - state=IDLE, `cnt`=0, shift register=0;
  - both pointers=0, `level`=0.
- **Reset values:**
  - `out_bit`=0, `out_valid`=0, `busy`=0, `level`=0, `in_ready`=1.
  - FIFO contents are don't-care.
- **Reset mid-word:** the partial word and all buffered words are discarded. No further bits are emitted.
- **Input while `rst` is high:** a word presented with `in_valid` high is not stored, even though `in_ready` reads 1.

## Timing
- **Latency into an empty, idle block:** word pushed at edge k; loaded into the shifter at edge k+1.
  - Bit DATA_W-1 is on `out_bit` from edge k+1 to edge k+2.
  - Bit 0 is presented from edge k+DATA_W to edge k+DATA_W+1.
- **Throughput:** one bit per cycle sustained.
- **Word spacing:** consecutive buffered words are emitted with zero idle cycles between them.
- **Output timing:** `out_bit` and `out_valid` are registered-state functions with no combinational path from `in_*`. The detector samples them on the next rising edge.

## Configuration
- **`SER_LSB_FIRST_EN`**
  - Defined: each word is emitted LSB first. `out_bit` = shift register bit 0, and shifts are right with zero fill.
  - Undefined (default): each word is emitted MSB first, as described above.
- The FSM, FIFO, handshake and timing are identical in both builds.

## Test plan
- **Reset values:** hold `rst`=1 for 2 cycles while `in_valid`=1 → `out_valid`=0, `out_bit`=0, `level`=0, `in_ready`=1; nothing is stored.
- **Single word:** push 8'hB4 at edge k into an idle block → `out_valid`=1 for exactly 8 cycles starting after edge k+1.
  - `out_bit` sequence: 1,0,1,1,0,1,0,0.
  - With `SER_LSB_FIRST_EN`: 0,0,1,0,1,1,0,1.
- **Back-to-back:** push 8'hFF, 8'h00, 8'hA5 on consecutive cycles → 24 contiguous `out_valid` cycles with no gap. Stream is 11111111 00000000 10100101.
- **Full FIFO:** with the shifter busy, push 4 words → `level`=4 and `in_ready`=0.
  - A fifth word held on `in_valid` is accepted only in the cycle after the next pop.
  - It is emitted in order after the other four.
- **Reset mid-word:** assert `rst` for one edge after 3 bits of 8'hB4, with 2 words queued → from that edge `out_valid`=0 and `level`=0. No remaining bits appear.
- **End to end:** drive the sequence detector with `out_bit`, and with its `rst_n` tied to `out_valid`.
  - Stream a word list that contains the target pattern at a known offset.
  - Required: the detector `out` asserts at exactly that bit index.
